// File: rtl/axi_lite_gpio.sv
// AXI-Lite GPIO: LED register, synchronized buttons with per-bit rising-edge interrupts.
// Optional per-button debounce is enabled by defining GPIO_DEBOUNCE_EN.
module axi_lite_gpio #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [3:0]  awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  input  logic [3:0]  araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  output logic [7:0]  led,
  input  logic [3:0]  btn,
  output logic        irq,
  input  logic        eoi
);

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  localparam logic [1:0] A_LED  = 2'd0;
  localparam logic [1:0] A_BTN  = 2'd1;
  localparam logic [1:0] A_STAT = 2'd2;
  localparam logic [1:0] A_MASK = 2'd3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  w_state_t    w_state, w_next;
  r_state_t    r_state, r_next;
  logic        ready_en;
  logic [1:0]  gate_cnt;
  logic [3:0]  irq_mask, irq_status, status_d, clr, btn_rise;
  logic [3:0]  sync1, sync2, btn_q, btn_prev;
  logic [1:0]  w_addr, r_addr;
  logic        w_fire, r_fire;
  logic [31:0] rd_mux;
  logic        unused_ok;

  assign w_addr = awaddr[3:2];
  assign r_addr = araddr[3:2];

  // ready_en keeps every ready low while in reset and for the first cycle after it
  assign w_fire = (w_state == W_IDLE) && ready_en && awvalid && wvalid;
  assign r_fire = (r_state == R_IDLE) && ready_en && arvalid;

  assign unused_ok = ^{wdata[31:8], wstrb[3:1], awaddr[1:0], araddr[1:0], DEBOUNCE_CYCLES};

  // ---------------- write FSM ----------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) w_state <= W_IDLE;
    else         w_state <= w_next;
  end

  always_comb begin
    w_next = w_state;
    unique case (w_state)
      W_IDLE: if (w_fire) w_next = W_RESP;
      W_RESP: if (bready) w_next = W_IDLE;
    endcase
  end

  always_comb begin
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    unique case (w_state)
      W_IDLE: begin
        awready = w_fire;
        wready  = w_fire;
      end
      W_RESP: bvalid = 1'b1;
    endcase
  end

  // ---------------- read FSM ----------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= R_IDLE;
    else         r_state <= r_next;
  end

  always_comb begin
    r_next = r_state;
    unique case (r_state)
      R_IDLE: if (r_fire) r_next = R_DATA;
      R_DATA: if (rready) r_next = R_IDLE;
    endcase
  end

  always_comb begin
    arready = 1'b0;
    rvalid  = 1'b0;
    unique case (r_state)
      R_IDLE: arready = ready_en;
      R_DATA: rvalid  = 1'b1;
    endcase
  end

  assign rresp = RESP_OKAY;

  always_comb begin
    rd_mux = '0;
    unique case (r_addr)
      A_LED:  rd_mux[7:0] = led;
      A_BTN:  rd_mux[3:0] = btn_q;
      A_STAT: rd_mux[3:0] = irq_status;
      A_MASK: rd_mux[3:0] = irq_mask;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)     rdata <= '0;
    else if (r_fire) rdata <= rd_mux;
  end

  // ---------------- registers ----------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      led      <= '0;
      irq_mask <= '0;
      bresp    <= '0;
    end else if (w_fire) begin
      bresp <= (w_addr == A_BTN) ? RESP_SLVERR : RESP_OKAY;
      if (wstrb[0]) begin
        unique case (w_addr)
          A_LED:   led      <= wdata[7:0];
          A_MASK:  irq_mask <= wdata[3:0];
          default: ;
        endcase
      end
    end
  end

  // Clear sources (W1C and eoi) merge first; a same-cycle edge is OR-ed in last so it wins.
  always_comb begin
    clr = '0;
    if (w_fire && (w_addr == A_STAT) && wstrb[0]) clr = wdata[3:0];
    if (eoi) clr = '1;
    btn_rise = btn_q & ~btn_prev & {4{gate_cnt == 2'd3}};
    status_d = (irq_status & ~clr) | btn_rise;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      irq_status <= '0;
      irq        <= 1'b0;
    end else begin
      irq_status <= status_d;
      irq        <= |(irq_status & irq_mask);
    end
  end

  // ---------------- button path ----------------
  // Edge detect stays gated until the synchronizer has flushed its reset zeros,
  // so buttons already held at release never look like a fresh press.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1    <= '0;
      sync2    <= '0;
      btn_prev <= '0;
      gate_cnt <= '0;
      ready_en <= 1'b0;
    end else begin
      sync1    <= btn;
      sync2    <= sync1;
      btn_prev <= btn_q;
      ready_en <= 1'b1;
      if (gate_cnt != 2'd3) gate_cnt <= gate_cnt + 2'd1;
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  logic [15:0] db_cnt [4];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      btn_q <= '0;
      for (int unsigned i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (sync2[i] != btn_q[i]) begin
          if (db_cnt[i] + 16'd1 >= DEBOUNCE_CYCLES) begin
            btn_q[i]  <= sync2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 16'd1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end
`else
  assign btn_q = sync2;
`endif

endmodule

// File: tb/tb_axi_lite_gpio.sv
// Bench for axi_lite_gpio: directed register scenarios, then randomized traffic,
// all checked every cycle against a transaction-level model of the register map.
`timescale 1ns/1ps
module tb_axi_lite_gpio;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [3:0]  awaddr = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b1;
  logic [3:0]  araddr = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b1;
  logic [7:0]  led;
  logic [3:0]  btn = 4'hF;
  logic        irq;
  logic        eoi = 1'b0;

  int total = 0;
  int bad   = 0;

  axi_lite_gpio dut (
    .clk(clk), .resetn(resetn),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .led(led), .btn(btn), .irq(irq), .eoi(eoi)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Model state: register contents, channel occupancy, and the raw button history
  // (h0 = last sample, h1 = two samples ago = the visible BTN value).
  typedef struct packed {
    logic [7:0]  led;
    logic [3:0]  mask;
    logic [3:0]  status;
    logic        irq;
    logic        wbusy;
    logic [1:0]  bresp;
    logic        rbusy;
    logic [31:0] rdata;
    logic [3:0]  h0;
    logic [3:0]  h1;
    logic [3:0]  h2;
    logic [7:0]  edges;
  } mdl_t;

  mdl_t m;

  function automatic logic [31:0] reg_value(input mdl_t s, input logic [1:0] a);
    case (a)
      2'd0:    return {24'd0, s.led};
      2'd1:    return {28'd0, s.h1};
      2'd2:    return {28'd0, s.status};
      default: return {28'd0, s.mask};
    endcase
  endfunction

  function automatic mdl_t step(input mdl_t s);
    mdl_t n;
    logic [3:0] clr;
    logic [3:0] rise;
    logic alive;
    n = s;
    alive = (s.edges != 8'd0);
    clr = eoi ? 4'hF : 4'h0;
    rise = (s.edges >= 8'd3) ? (s.h1 & ~s.h2) : 4'h0;
    if (!s.rbusy && alive && arvalid) begin
      n.rbusy = 1'b1;
      n.rdata = reg_value(s, araddr[3:2]);
    end else if (s.rbusy && rready) begin
      n.rbusy = 1'b0;
    end
    if (!s.wbusy && alive && awvalid && wvalid) begin
      n.wbusy = 1'b1;
      n.bresp = (awaddr[3:2] == 2'd1) ? 2'b10 : 2'b00;
      if (wstrb[0]) begin
        if (awaddr[3:2] == 2'd0) n.led = wdata[7:0];
        if (awaddr[3:2] == 2'd2) clr = clr | wdata[3:0];
        if (awaddr[3:2] == 2'd3) n.mask = wdata[3:0];
      end
    end else if (s.wbusy && bready) begin
      n.wbusy = 1'b0;
    end
    n.status = (s.status & ~clr) | rise;
    n.irq = |(s.status & s.mask);
    n.h2 = s.h1;
    n.h1 = s.h0;
    n.h0 = btn;
    if (s.edges != 8'hFF) n.edges = s.edges + 8'd1;
    return n;
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) m <= '0;
    else         m <= step(m);
  end

  logic exp_wr_hs;
  logic exp_arready;
  assign exp_wr_hs   = !m.wbusy && (m.edges != 8'd0) && awvalid && wvalid;
  assign exp_arready = !m.rbusy && (m.edges != 8'd0);

  always @(negedge clk) begin
    check("led",     32'(led),     32'(m.led));
    check("irq",     32'(irq),     32'(m.irq));
    check("awready", 32'(awready), 32'(exp_wr_hs));
    check("wready",  32'(wready),  32'(exp_wr_hs));
    check("bvalid",  32'(bvalid),  32'(m.wbusy));
    check("bresp",   32'(bresp),   32'(m.bresp));
    check("arready", 32'(arready), 32'(exp_arready));
    check("rvalid",  32'(rvalid),  32'(m.rbusy));
    check("rdata",   rdata,        m.rdata);
    check("rresp",   32'(rresp),   32'd0);
  end

  task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp, output int hi);
    logic ok;
    @(posedge clk); #1;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (awready && wready) ok = 1'b1;
    end
    check("wr_accept", 32'(ok), 32'd1);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    resp = 2'b11; hi = 0; ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (bvalid) begin
        resp = bresp;
        hi++;
      end else if (hi > 0) begin
        ok = 1'b1;
      end
    end
    check("wr_resp_done", 32'(ok), 32'd1);
  endtask

  task automatic do_read(input logic [3:0] a, output logic [31:0] d);
    logic ok;
    @(posedge clk); #1;
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (arready) ok = 1'b1;
    end
    check("rd_accept", 32'(ok), 32'd1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    d = 32'hDEAD_BEEF; ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (rvalid) begin
        d = rdata;
        ok = 1'b1;
      end
    end
    check("rd_data_seen", 32'(ok), 32'd1);
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] first;
    logic [1:0]  resp;
    int          hi;
    int          cnt;
    logic        ok;

    // In reset with buttons held and a write presented: nothing may respond.
    awvalid = 1'b1; wvalid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_led", 32'(led), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_awready", 32'(awready), 32'd0);
    check("rst_arready", 32'(arready), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    awvalid = 1'b0; wvalid = 1'b0;
    resetn = 1'b1;
    repeat (10) @(posedge clk);
    do_read(4'h8, d);
    check("held_btn_no_status", d, 32'h0);
    do_read(4'h4, d);
    check("btn_read_high", d, 32'hF);
    #1 btn = 4'h0;
    repeat (4) @(posedge clk);

    // LED write / readback and single-cycle response.
    do_write(4'h0, 32'h0000_00A5, 4'b0001, resp, hi);
    check("led_a5", 32'(led), 32'hA5);
    check("led_wr_resp", 32'(resp), 32'd0);
    check("bvalid_cycles", 32'(hi), 32'd1);
    do_read(4'h0, d);
    check("led_readback", d, 32'h0000_00A5);
    do_write(4'h0, 32'h0000_003C, 4'b1110, resp, hi);
    do_read(4'h0, d);
    check("led_strb_off", d, 32'h0000_00A5);

    // Masked button interrupt, then W1C clear.
    do_write(4'hC, 32'h1, 4'b0001, resp, hi);
    @(posedge clk); #1 btn[0] = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("irq_from_btn0", 32'(irq), 32'd1);
    do_read(4'h8, d);
    check("status_btn0", d, 32'h1);
    do_write(4'h8, 32'h1, 4'b0001, resp, hi);
    @(posedge clk); #1;
    check("irq_after_w1c", 32'(irq), 32'd0);
    btn[0] = 1'b0;
    repeat (4) @(posedge clk);

    // BTN is read-only; address without data never handshakes.
    do_write(4'h4, 32'hFFFF_FFFF, 4'hF, resp, hi);
    check("btn_wr_slverr", 32'(resp), 32'h2);
    do_read(4'h4, d);
    check("btn_unchanged", d, 32'h0);
    @(posedge clk); #1;
    awaddr = 4'h0; wdata = 32'h0000_0011; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b0;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (awready) cnt++;
    end
    check("aw_without_w", 32'(cnt), 32'd0);
    @(posedge clk); #1 awvalid = 1'b0;
    check("led_kept", 32'(led), 32'hA5);

    // Button edge landing on the same edge as a W1C of that bit: the set wins.
    @(posedge clk); #1 btn[2] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    awaddr = 4'h8; wdata = 32'h4; wstrb = 4'b0001; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    repeat (2) @(posedge clk);
    do_read(4'h8, d);
    check("set_beats_clear", d, 32'h4);
    @(posedge clk); #1 eoi = 1'b1;
    @(posedge clk); #1 eoi = 1'b0;
    do_read(4'h8, d);
    check("eoi_clears", d, 32'h0);

    // Read stalled by rready=0 holds data.
    @(posedge clk); #1 btn[1] = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rready = 1'b0; araddr = 4'h8; arvalid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (arready) ok = 1'b1;
    end
    check("stall_rd_accept", 32'(ok), 32'd1);
    @(posedge clk); #1 arvalid = 1'b0;
    @(negedge clk);
    first = rdata;
    check("stall_rd_data", first, 32'h2);
    ok = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (!rvalid || rdata !== first) ok = 1'b0;
    end
    check("stall_rd_hold", 32'(ok), 32'd1);
    @(posedge clk); #1 rready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("stall_rd_release", 32'(rvalid), 32'd0);

    // Reset while a write response is pending.
    @(posedge clk); #1;
    awaddr = 4'h0; wdata = 32'hFF; wstrb = 4'b0001; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    check("led_ff", 32'(led), 32'hFF);
    check("bvalid_pending", 32'(bvalid), 32'd1);
    resetn = 1'b0;
    #1;
    check("rst_kills_bvalid", 32'(bvalid), 32'd0);
    check("rst_kills_led", 32'(led), 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1; bready = 1'b1;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (bvalid) cnt++;
    end
    check("no_resp_after_rst", 32'(cnt), 32'd0);
    check("led_after_rst", 32'(led), 32'd0);

    // Randomized traffic; the per-cycle compare does the checking.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      resetn  = ($urandom_range(0, 599) != 0);
      awvalid = ($urandom_range(0, 2) == 0);
      wvalid  = ($urandom_range(0, 2) != 0);
      awaddr  = 4'($urandom);
      wdata   = $urandom;
      wstrb   = 4'($urandom);
      bready  = ($urandom_range(0, 1) == 1);
      arvalid = ($urandom_range(0, 2) == 0);
      araddr  = 4'($urandom);
      rready  = ($urandom_range(0, 1) == 1);
      eoi     = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 5) == 0) btn[$urandom_range(0, 3)] ^= 1'b1;
    end
    @(posedge clk); #1;
    resetn = 1'b1; awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; eoi = 1'b0;
    bready = 1'b1; rready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
